// File: rtl/instr_loader.sv
// Boot-time program loader: streams machine-code words into instruction memory,
// releases the core from reset, and supervises its run until Done or timeout.
module instr_loader #(
  parameter int          IW      = 9,
  parameter int          AW      = 6,
  parameter int          DEPTH   = 64,
  parameter logic [15:0] MAX_CYC = 16'hFFFF
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [IW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [IW-1:0] wr_data,
  output logic          core_reset,
  input  logic          core_done,
  output logic          busy,
  output logic          finished,
  output logic          err_overflow,
  output logic          err_timeout,
  output logic [AW:0]   word_count,
  output logic [15:0]   run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FINISH,
    S_ERR
  } state_t;

  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] WC_ONE   = (AW+1)'(1);

  state_t          state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [IW-1:0]   wr_data_q, wr_data_d;
  logic            core_reset_q, core_reset_d;
  logic            busy_q, busy_d;
  logic            finished_q, finished_d;
  logic            err_overflow_q, err_overflow_d;
  logic            err_timeout_q, err_timeout_d;
  logic [AW:0]     word_count_q, word_count_d;
  logic [15:0]     run_cycles_q, run_cycles_d;
  logic            xfer;
  logic [15:0]     cyc_inc;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q        <= S_IDLE;
      in_ready_q     <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      core_reset_q   <= 1'b1;
      busy_q         <= 1'b0;
      finished_q     <= 1'b0;
      err_overflow_q <= 1'b0;
      err_timeout_q  <= 1'b0;
      word_count_q   <= '0;
      run_cycles_q   <= '0;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      core_reset_q   <= core_reset_d;
      busy_q         <= busy_d;
      finished_q     <= finished_d;
      err_overflow_q <= err_overflow_d;
      err_timeout_q  <= err_timeout_d;
      word_count_q   <= word_count_d;
      run_cycles_q   <= run_cycles_d;
    end
  end

  // in_ready_q mirrors state LOAD, so it alone qualifies the handshake
  assign xfer    = (state_q == S_LOAD) && in_valid && in_ready_q;
  assign cyc_inc = (run_cycles_q == MAX_CYC) ? run_cycles_q : run_cycles_q + 16'd1;

  always_comb begin
    state_d        = state_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    finished_d     = finished_q;
    err_overflow_d = err_overflow_q;
    err_timeout_d  = err_timeout_q;
    word_count_d   = word_count_q;
    run_cycles_d   = run_cycles_q;

    case (state_q)
      S_IDLE, S_FINISH, S_ERR: begin
        if (start) begin
          state_d        = S_LOAD;
          finished_d     = 1'b0;
          err_overflow_d = 1'b0;
          err_timeout_d  = 1'b0;
          word_count_d   = '0;
          run_cycles_d   = '0;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          wr_en_d      = 1'b1;
          wr_addr_d    = word_count_q[AW-1:0];
          wr_data_d    = in_data;
          word_count_d = word_count_q + WC_ONE;
          if (in_last) begin
            state_d = S_RUN;
          end else if (word_count_q == LAST_IDX) begin
            state_d        = S_ERR;
            err_overflow_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        run_cycles_d = cyc_inc;
        // Done takes priority over a budget expiring on the same cycle
        if (core_done) begin
          state_d    = S_FINISH;
          finished_d = 1'b1;
        end else if (cyc_inc == MAX_CYC) begin
          state_d       = S_ERR;
          err_timeout_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered decodes; core_reset releases only once RUN is already the
  // current state, so the final write lands before the core starts fetching.
  always_comb begin
    in_ready_d   = (state_d == S_LOAD);
    busy_d       = (state_d == S_LOAD) || (state_d == S_RUN);
    core_reset_d = !((state_q == S_RUN) && (state_d == S_RUN));
  end

  assign in_ready     = in_ready_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign core_reset   = core_reset_q;
  assign busy         = busy_q;
  assign finished     = finished_q;
  assign err_overflow = err_overflow_q;
  assign err_timeout  = err_timeout_q;
  assign word_count   = word_count_q;
  assign run_cycles   = run_cycles_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed/randomized bench for instr_loader with a queue-based write model.
module tb_instr_loader;
  localparam int          IW   = 9;
  localparam int          AW   = 6;
  localparam int          DEPTH = 64;
  localparam logic [15:0] MAXC = 16'd20;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          core_done = 1'b0;
  logic          in_ready, wr_en, core_reset, busy, finished, err_overflow, err_timeout;
  logic [AW-1:0] wr_addr;
  logic [IW-1:0] wr_data;
  logic [AW:0]   word_count;
  logic [15:0]   run_cycles;

  int errors = 0;
  int checks = 0;
  logic [AW+IW-1:0] obs_q[$];
  logic [AW+IW-1:0] exp_q[$];
  logic [IW-1:0]    prog[$];
  int cyc = 0;
  int last_wr_cyc = -1;
  int first_cr_low = -1;
  bit wr_while_run = 1'b0;
  bit cr_released = 1'b0;

  instr_loader #(.IW(IW), .AW(AW), .DEPTH(DEPTH), .MAX_CYC(MAXC)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .core_reset(core_reset), .core_done(core_done), .busy(busy),
    .finished(finished), .err_overflow(err_overflow), .err_timeout(err_timeout),
    .word_count(word_count), .run_cycles(run_cycles)
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // Observe the memory write port and core reset on the inactive edge
  always @(negedge Clk) begin
    cyc = cyc + 1;
    if (wr_en === 1'b1) begin
      obs_q.push_back({wr_addr, wr_data});
      last_wr_cyc = cyc;
      if (core_reset !== 1'b1) wr_while_run = 1'b1;
    end
    if (core_reset === 1'b0) begin
      cr_released = 1'b1;
      if (first_cr_low < 0) first_cr_low = cyc;
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_core_reset"}, core_reset, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_finished"}, finished, 0);
    chk({tag, "_err_ovf"}, err_overflow, 0);
    chk({tag, "_err_to"}, err_timeout, 0);
    chk({tag, "_word_count"}, word_count, 0);
    chk({tag, "_run_cycles"}, run_cycles, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic rand_prog(input int n);
    prog.delete();
    repeat (n) prog.push_back(IW'($urandom));
  endtask

  // Streams prog; the expected memory image is simply word i at address i.
  task automatic load(input bit with_last, input int gap_max, input bit poke_start);
    for (int i = 0; i < prog.size(); i++) begin
      int gaps;
      int w;
      gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (gaps) begin
        in_valid = 1'b0;
        in_data  = IW'($urandom);
        in_last  = 1'($urandom);
        start    = poke_start ? 1'($urandom) : 1'b0;
        step();
      end
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = prog[i];
      in_last  = with_last && (i == prog.size() - 1);
      w = 0;
      while (in_ready !== 1'b1 && w < 20) begin
        step();
        w++;
      end
      if (w >= 20) chk("ready_wait", in_ready, 1);
      exp_q.push_back({AW'(i), prog[i]});
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk({tag, "_addr_data"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // Power-on reset
    Reset = 1'b0;
    step();
    step();
    chk_reset("por");
    Reset = 1'b1;
    step();

    // Fixed 3-word program, core_done in the 10th RUN cycle
    pulse_start();
    chk("t1_busy", busy, 1);
    chk("t1_in_ready", in_ready, 1);
    chk("t1_core_reset_load", core_reset, 1);
    prog = {9'h1A3, 9'h055, 9'h1FF};
    last_wr_cyc = -1;
    first_cr_low = -1;
    wr_while_run = 1'b0;
    load(1'b1, 0, 1'b0);
    chk("t1_in_ready_drop", in_ready, 0);
    repeat (9) step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk("t1_finished", finished, 1);
    chk("t1_run_cycles", run_cycles, 10);
    chk("t1_core_reset", core_reset, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_err_to", err_timeout, 0);
    chk("t1_word_count", word_count, 3);
    check_writes("t1_wr");
    chk("t1_cr_fall_after_last_wr", 32'(first_cr_low - last_wr_cyc), 1);
    chk("t1_no_write_in_run", wr_while_run, 0);

    // 64 words without in_last: overflow, core never released
    pulse_start();
    chk("t3_wc_clear", word_count, 0);
    chk("t3_fin_clear", finished, 0);
    cr_released = 1'b0;
    rand_prog(DEPTH);
    load(1'b0, 2, 1'b0);
    step();
    chk("t3_err_ovf", err_overflow, 1);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_busy", busy, 0);
    chk("t3_core_reset", core_reset, 1);
    chk("t3_word_count", word_count, DEPTH);
    chk("t3_err_to", err_timeout, 0);
    check_writes("t3_wr");
    chk("t3_cr_never_low", cr_released, 0);
    in_valid = 1'b1;
    in_last  = 1'b1;
    repeat (3) begin
      in_data = IW'($urandom);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    step();
    check_writes("t3_err_ignores_valid");

    // Random program, gapped valid, stray start pulses; done exactly at budget
    pulse_start();
    chk("t4_ovf_clear", err_overflow, 0);
    rand_prog(int'($urandom_range(1, 20)));
    load(1'b1, 3, 1'b1);
    repeat (19) step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk("t4_finished", finished, 1);
    chk("t4_err_to", err_timeout, 0);
    chk("t4_run_cycles", run_cycles, MAXC);
    chk("t4_word_count", word_count, prog.size());
    check_writes("t4_wr");

    // Budget expires with core_done held low
    pulse_start();
    rand_prog(2);
    load(1'b1, 0, 1'b0);
    repeat (19) step();
    chk("t5_busy_pre", busy, 1);
    chk("t5_err_to_pre", err_timeout, 0);
    chk("t5_run_cycles_pre", run_cycles, 19);
    step();
    chk("t5_err_to", err_timeout, 1);
    chk("t5_finished", finished, 0);
    chk("t5_run_cycles", run_cycles, MAXC);
    chk("t5_core_reset", core_reset, 1);
    chk("t5_busy", busy, 0);
    core_done = 1'b1;
    repeat (3) step();
    core_done = 1'b0;
    chk("t5_err_hold_fin", finished, 0);
    chk("t5_err_hold_cyc", run_cycles, MAXC);
    check_writes("t5_wr");

    // Asynchronous reset mid-RUN, then a fresh 1-word load
    pulse_start();
    rand_prog(1);
    load(1'b1, 0, 1'b0);
    repeat (4) step();
    chk("t6_busy_run", busy, 1);
    check_writes("t6_wr_pre");
    #2 Reset = 1'b0;
    #1 chk_reset("t6_async");
    step();
    chk_reset("t6_held");
    Reset = 1'b1;
    step();
    pulse_start();
    chk("t6_ovf", err_overflow, 0);
    chk("t6_to", err_timeout, 0);
    chk("t6_fin", finished, 0);
    rand_prog(1);
    load(1'b1, 0, 1'b0);
    step();
    chk("t6_word_count", word_count, 1);
    check_writes("t6_wr_post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
